// File: rtl/intlv_wr_ctrl.sv
// Interleaver write-side controller: maps each accepted coded bit k onto its
// first-permutation buffer address using an incremental row/column walk.
module intlv_wr_ctrl #(
  parameter int NCBPS  = 192,
  parameter int D      = 16,
  parameter int ADDR_W = 9,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              data_in,
  input  logic              valid_in,
  input  logic              sof_in,
  output logic              ready_out,
  output logic [ADDR_W-1:0] wraddress,
  output logic              wrdata,
  output logic              valid_prev,
  output logic              block_done,
  output logic              sof_err,
  output logic [CNT_W-1:0]  block_cnt
);

  // state | meaning
  // IDLE  | k = 0, next accepted bit opens a block
  // FILL  | 0 < k < NCBPS, block in progress
  typedef enum logic {IDLE, FILL} state_t;

  localparam logic [ADDR_W-1:0] STEP      = ADDR_W'(NCBPS / D);
  localparam logic [ADDR_W-1:0] LAST_COL  = ADDR_W'(D - 1);
  localparam logic [ADDR_W-1:0] LAST_BASE = ADDR_W'(NCBPS / D - 1);
  localparam logic [ADDR_W-1:0] ONE       = ADDR_W'(1);
  localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);

  state_t            r_state;
  state_t            w_state_nxt;
  logic [ADDR_W-1:0] r_addr;
  logic [ADDR_W-1:0] r_col;
  logic [ADDR_W-1:0] r_base;
  logic [ADDR_W-1:0] w_cur_addr;
  logic [ADDR_W-1:0] w_cur_col;
  logic [ADDR_W-1:0] w_cur_base;
  logic [ADDR_W-1:0] w_addr_nxt;
  logic [ADDR_W-1:0] w_col_nxt;
  logic [ADDR_W-1:0] w_base_nxt;
  logic              w_restart;
  logic              w_last;

  assign ready_out = (r_state == IDLE) || (r_state == FILL);

  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  // A mid-block sof restarts the walk so the current bit lands on k = 0.
  always_comb begin
    w_restart  = valid_in && sof_in && (r_state == FILL);
    w_cur_addr = w_restart ? '0 : r_addr;
    w_cur_col  = w_restart ? '0 : r_col;
    w_cur_base = w_restart ? '0 : r_base;
    w_last     = (w_cur_col == LAST_COL) && (w_cur_base == LAST_BASE);
    w_addr_nxt = w_cur_addr + STEP;
    w_col_nxt  = w_cur_col + ONE;
    w_base_nxt = w_cur_base;
    if (w_last) begin
      w_addr_nxt = '0;
      w_col_nxt  = '0;
      w_base_nxt = '0;
    end else if (w_cur_col == LAST_COL) begin
      w_addr_nxt = w_cur_base + ONE;
      w_col_nxt  = '0;
      w_base_nxt = w_cur_base + ONE;
    end
    w_state_nxt = r_state;
    if (valid_in) w_state_nxt = w_last ? IDLE : FILL;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_addr     <= '0;
      r_col      <= '0;
      r_base     <= '0;
      wraddress  <= '0;
      wrdata     <= 1'b0;
      valid_prev <= 1'b0;
      block_done <= 1'b0;
      sof_err    <= 1'b0;
      block_cnt  <= '0;
    end else begin
      valid_prev <= valid_in;
      block_done <= valid_in && w_last;
      sof_err    <= w_restart;
      if (valid_in) begin
        wraddress <= w_cur_addr;
        wrdata    <= data_in;
        r_addr    <= w_addr_nxt;
        r_col     <= w_col_nxt;
        r_base    <= w_base_nxt;
        if (w_last) block_cnt <= block_cnt + CNT_ONE;
      end
    end
  end

endmodule

// File: tb/tb_intlv_wr_ctrl.sv
// Self-checking bench for intlv_wr_ctrl: directed scenarios plus random
// traffic, compared against a k-indexed reference of the permutation.
module tb_intlv_wr_ctrl;

  localparam int NCBPS  = 192;
  localparam int D      = 16;
  localparam int ADDR_W = 9;
  localparam int CNT_W  = 16;
  localparam int STEP   = NCBPS / D;

  logic              clk = 1'b0;
  logic              reset;
  logic              data_in;
  logic              valid_in;
  logic              sof_in;
  logic              ready_out;
  logic [ADDR_W-1:0] wraddress;
  logic              wrdata;
  logic              valid_prev;
  logic              block_done;
  logic              sof_err;
  logic [CNT_W-1:0]  block_cnt;

  intlv_wr_ctrl #(.NCBPS(NCBPS), .D(D), .ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .data_in(data_in), .valid_in(valid_in),
    .sof_in(sof_in), .ready_out(ready_out), .wraddress(wraddress),
    .wrdata(wrdata), .valid_prev(valid_prev), .block_done(block_done),
    .sof_err(sof_err), .block_cnt(block_cnt)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // reference state: position in block, expected registered outputs
  int          m_k = 0;
  int          e_addr = 0, e_cnt = 0;
  logic        e_data = 0, e_vp = 0, e_done = 0, e_err = 0;
  logic        k_bits [NCBPS];
  int          img_cnt [NCBPS];
  logic        img_dat [NCBPS];
  logic [191:0] pat = 192'h2833E48D392026D5B6DC5E4AF47ADD29494B6C89151348CA;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int perm(input int k);
    return STEP * (k % D) + k / D;
  endfunction

  task automatic clear_img();
    for (int a = 0; a < NCBPS; a++) begin
      img_cnt[a] = 0;
      img_dat[a] = 1'b0;
    end
  endtask

  task automatic step(input logic rst, input logic v, input logic d, input logic s);
    int nbad;
    @(negedge clk);
    reset = rst; valid_in = v; data_in = d; sof_in = s;
    @(posedge clk);
    if (rst) begin
      m_k = 0; e_addr = 0; e_data = 0; e_vp = 0; e_done = 0; e_err = 0; e_cnt = 0;
      clear_img();
    end else if (v) begin
      e_err = s && (m_k != 0);
      if (e_err) m_k = 0;
      if (m_k == 0) clear_img();
      k_bits[m_k] = d;
      e_addr = perm(m_k);
      e_data = d;
      e_vp   = 1'b1;
      e_done = (m_k == NCBPS - 1);
      if (e_done) e_cnt = (e_cnt + 1) % (1 << CNT_W);
      m_k = e_done ? 0 : m_k + 1;
    end else begin
      e_vp = 1'b0; e_done = 1'b0; e_err = 1'b0;
    end
    #1;
    chk("ready_out", ready_out, 1);
    chk("valid_prev", valid_prev, e_vp);
    chk("wraddress", wraddress, e_addr);
    chk("wrdata", wrdata, e_data);
    chk("block_done", block_done, e_done);
    chk("sof_err", sof_err, e_err);
    chk("block_cnt", block_cnt, e_cnt);
    if (valid_prev && wraddress < NCBPS) begin
      img_cnt[wraddress]++;
      img_dat[wraddress] = wrdata;
    end
    if (block_done) begin
      // each address exactly once, holding the bit that k = inverse(addr) carried
      nbad = 0;
      for (int a = 0; a < NCBPS; a++)
        if (img_cnt[a] != 1 || img_dat[a] !== k_bits[(a % STEP) * D + a / STEP]) nbad++;
      chk("image", nbad, 0);
      clear_img();
    end
  endtask

  task automatic stream_pat(input int pct_gap);
    int k = 0;
    while (k < NCBPS) begin
      if ($urandom_range(99) < pct_gap) step(0, 0, $urandom_range(1), $urandom_range(1));
      else begin
        step(0, 1, pat[k], k == 0);
        k++;
      end
    end
  endtask

  task automatic stream_rand(input int n);
    for (int i = 0; i < n; i++) step(0, 1, $urandom_range(1), 1'b0);
  endtask

  initial begin
    reset = 1; valid_in = 0; data_in = 0; sof_in = 0;
    // 1: reset held with valid high
    for (int i = 0; i < 3; i++) step(1, 1, 1, 1);
    // 2: continuous pattern block
    stream_pat(0);
    step(0, 0, 0, 0);
    chk("cnt_after_block", block_cnt, 1);
    // 3: pattern with ~30% gaps
    stream_pat(30);
    step(0, 0, 0, 0);
    chk("cnt_after_gaps", block_cnt, 2);
    // 4: ten back-to-back blocks
    for (int b = 0; b < 10; b++) stream_pat(0);
    step(0, 0, 0, 0);
    chk("cnt_after_b2b", block_cnt, 12);
    // 5: sof at k=100 abandons the partial block
    stream_rand(100);
    step(0, 1, 1, 1);
    chk("sof_restart_err", sof_err, 1);
    chk("sof_restart_addr", wraddress, 0);
    stream_rand(NCBPS - 1);
    step(0, 0, 0, 0);
    chk("cnt_after_sof", block_cnt, 13);
    // 6: reset mid-block at k=50
    stream_rand(50);
    step(1, 1, 0, 0);
    stream_rand(NCBPS);
    step(0, 0, 0, 0);
    chk("cnt_after_reset", block_cnt, 1);
    // random traffic with occasional stray sof
    for (int i = 0; i < 4000; i++)
      step(0, $urandom_range(99) < 80, $urandom_range(1), $urandom_range(99) < 2);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
